// File: rtl/useq_ctrl_if.sv
// -----------------------------------------------------------------------------
// useq_ctrl_if
// Bundles the sequencer's control-store, datapath-status and status/debug
// signals.
//   master : the sequencer. It samples start/step/uword/opcode/flags and drives
//            uaddr, rom_en, exec_en, busy, halted, err and state_dbg.
//   slave  : the surrounding system (control store, IR, status register, panel).
// -----------------------------------------------------------------------------
interface useq_ctrl_if;
  logic        start;
  logic        step_mode;
  logic        step;
  logic [23:0] uword;
  logic [3:0]  opcode;
  logic        flag_c;
  logic        flag_z;
  logic [7:0]  uaddr;
  logic        rom_en;
  logic        exec_en;
  logic        busy;
  logic        halted;
  logic        err;
  logic [2:0]  state_dbg;

  modport master (
    input  start, step_mode, step, uword, opcode, flag_c, flag_z,
    output uaddr, rom_en, exec_en, busy, halted, err, state_dbg
  );

  modport slave (
    output start, step_mode, step, uword, opcode, flag_c, flag_z,
    input  uaddr, rom_en, exec_en, busy, halted, err, state_dbg
  );
endinterface

// File: rtl/useq_ctrl.sv
// -----------------------------------------------------------------------------
// useq_ctrl
// Microprogram sequencer. It fetches one 24-bit microword per instruction,
// issues it with a single exec_en strobe and resolves the next microaddress:
// sequential, dispatch, jump, carry/zero branch, call/return through a small
// return stack, and halt.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active-high
//   bus.start  : begin/restart execution (sampled in IDLE and HALT)
//   bus.step_mode / bus.step : single-step control
//   bus.uword  : control-store data, valid the cycle after rom_en
//   bus.opcode : IR opcode for dispatch
//   bus.flag_c / bus.flag_z : status flags, sampled in EXEC
//   bus.uaddr  : registered control-store address
//   bus.rom_en : fetch strobe
//   bus.exec_en: datapath write strobe
//   bus.busy / bus.halted / bus.err / bus.state_dbg : status and debug
// -----------------------------------------------------------------------------
module useq_ctrl #(
  parameter int         STACK_DEPTH = 4,
  parameter logic [7:0] RESET_ADDR  = 8'h00
) (
  input logic         clk,
  input logic         rst,
  useq_ctrl_if.master bus
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
  localparam logic [SP_W-1:0] SP_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_PAUSE = 3'd3,
    S_HALT  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    NAC_NEXT     = 3'd0,
    NAC_DISPATCH = 3'd1,
    NAC_JUMP     = 3'd2,
    NAC_BRC      = 3'd3,
    NAC_BRZ      = 3'd4,
    NAC_CALL     = 3'd5,
    NAC_RET      = 3'd6,
    NAC_HALT     = 3'd7
  } nac_t;

  state_t          state, state_nxt;
  logic [7:0]      uaddr, uaddr_nxt;
  logic [SP_W-1:0] sp, sp_nxt;
  logic            err_q, err_nxt;
  logic            push;
  logic [7:0]      stk [STACK_DEPTH];

  nac_t            nac;
  logic [7:0]      tgt;
  logic [7:0]      seq_addr;
  logic [SP_W-1:0] sp_dec;
  logic [7:0]      stk_top;
  logic            fault;
  logic            halt_req;

  assign nac      = nac_t'(bus.uword[2:0]);
  assign tgt      = bus.uword[20:13];
  assign seq_addr = uaddr + 8'd1;           // wraps FF -> 00 by design
  assign sp_dec   = sp - SP_ONE;
  assign stk_top  = stk[sp_dec[IDX_W-1:0]];

  // Datapath-only microword bits are not interpreted by the sequencer.
  logic unused_uword_bits;
  assign unused_uword_bits = ^{bus.uword[23:21], bus.uword[12:3]};

  // State, address, stack pointer and sticky fault
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      uaddr <= RESET_ADDR;
      sp    <= SP_ZERO;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      uaddr <= uaddr_nxt;
      sp    <= sp_nxt;
      err_q <= err_nxt;
    end
  end

  // Return stack storage; only the pointer needs a reset value.
  always_ff @(posedge clk) begin
    if (push) begin
      stk[sp[IDX_W-1:0]] <= seq_addr;
    end
  end

  // Next-state and next-address resolution
  always_comb begin
    state_nxt = state;
    uaddr_nxt = uaddr;
    sp_nxt    = sp;
    err_nxt   = err_q;
    push      = 1'b0;
    fault     = 1'b0;
    halt_req  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_FETCH;
          uaddr_nxt = RESET_ADDR;
          sp_nxt    = SP_ZERO;
        end
      end

      S_FETCH: state_nxt = S_EXEC;

      S_EXEC: begin
        unique case (nac)
          NAC_NEXT:     uaddr_nxt = seq_addr;
          NAC_DISPATCH: uaddr_nxt = {bus.opcode, 4'b0000};
          NAC_JUMP:     uaddr_nxt = tgt;
          NAC_BRC:      uaddr_nxt = bus.flag_c ? tgt : seq_addr;
          NAC_BRZ:      uaddr_nxt = bus.flag_z ? tgt : seq_addr;
          NAC_CALL: begin
            if (sp == SP_FULL) begin
              fault = 1'b1;
            end else begin
              push      = 1'b1;
              sp_nxt    = sp + SP_ONE;
              uaddr_nxt = tgt;
            end
          end
          NAC_RET: begin
            if (sp == SP_ZERO) begin
              fault = 1'b1;
            end else begin
              sp_nxt    = sp_dec;
              uaddr_nxt = stk_top;
            end
          end
          NAC_HALT:     halt_req = 1'b1;
          default:      uaddr_nxt = seq_addr;
        endcase

        // HALT wins over pause; a stack fault freezes address and stack.
        if (halt_req) begin
          state_nxt = S_HALT;
        end else if (fault) begin
          state_nxt = S_ERR;
          err_nxt   = 1'b1;
          uaddr_nxt = uaddr;
          sp_nxt    = sp;
        end else if (bus.step_mode) begin
          state_nxt = S_PAUSE;
        end else begin
          state_nxt = S_FETCH;
        end
      end

      S_PAUSE: begin
        if (bus.step || !bus.step_mode) begin
          state_nxt = S_FETCH;
        end
      end

      S_HALT: begin
        if (bus.start) begin
          state_nxt = S_FETCH;
          uaddr_nxt = RESET_ADDR;
          sp_nxt    = SP_ZERO;
        end
      end

      S_ERR: state_nxt = S_ERR;

      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes decode straight from the state register, so an asynchronous
  // reset removes them immediately.
  assign bus.uaddr     = uaddr;
  assign bus.rom_en    = (state == S_FETCH);
  assign bus.exec_en   = (state == S_EXEC);
  assign bus.busy      = (state == S_FETCH) || (state == S_EXEC) || (state == S_PAUSE);
  assign bus.halted    = (state == S_HALT);
  assign bus.err       = err_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_useq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_useq_ctrl
// Directed bench for useq_ctrl (RESET_ADDR=8'hFE, STACK_DEPTH=4). A
// control-store array feeds the DUT; an instruction-level model predicts every
// output each cycle, and directed checks pin literal addresses and states.
// -----------------------------------------------------------------------------
module tb_useq_ctrl;
  localparam logic [7:0] RA    = 8'hFE;
  localparam int         DEPTH = 4;

  localparam logic [2:0] N_NEXT = 3'd0, N_DISP = 3'd1, N_JUMP = 3'd2, N_BRC = 3'd3;
  localparam logic [2:0] N_BRZ  = 3'd4, N_CALL = 3'd5, N_RET  = 3'd6, N_HALT = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_exec = 0;
  int   prev_exec = 0;
  bit   cmp_on = 1'b0;

  logic [23:0] rom [256];
  logic [23:0] rom_q;

  useq_ctrl_if bus ();

  useq_ctrl #(.STACK_DEPTH(DEPTH), .RESET_ADDR(RA)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous control store: data appears the cycle after rom_en.
  always @(posedge clk) begin
    cyc++;
    if (bus.rom_en) rom_q <= rom[bus.uaddr];
  end
  assign bus.uword = rom_q;

  // ---------------------------------------------------------------------------
  // Instruction-level model: an address, a run/phase/pause view of progress,
  // and a queue for the return stack.
  // ---------------------------------------------------------------------------
  int m_addr = RA;
  bit m_run = 0, m_exec = 0, m_pause = 0, m_halt = 0, m_err = 0;
  int m_stk[$];

  always @(posedge clk or posedge rst) begin
    int w, nac, t, nx;
    bit stop;
    if (rst) begin
      m_addr = RA; m_run = 0; m_exec = 0; m_pause = 0; m_halt = 0; m_err = 0;
      m_stk.delete();
    end else if (m_err) begin
      m_err = 1;
    end else if (!m_run) begin
      if (bus.start) begin
        m_run = 1; m_exec = 0; m_pause = 0; m_halt = 0;
        m_addr = RA;
        m_stk.delete();
      end
    end else if (m_pause) begin
      if (bus.step || !bus.step_mode) m_pause = 0;
    end else if (!m_exec) begin
      m_exec = 1;
    end else begin
      m_exec = 0;
      stop = 0;
      w   = int'(rom[m_addr]);
      nac = w & 7;
      t   = (w >> 13) & 255;
      nx  = (m_addr + 1) % 256;
      case (nac)
        0: m_addr = nx;
        1: m_addr = int'(bus.opcode) * 16;
        2: m_addr = t;
        3: m_addr = bus.flag_c ? t : nx;
        4: m_addr = bus.flag_z ? t : nx;
        5: if (m_stk.size() == DEPTH) begin m_err = 1; stop = 1; end
           else begin m_stk.push_back(nx); m_addr = t; end
        6: if (m_stk.size() == 0) begin m_err = 1; stop = 1; end
           else m_addr = m_stk.pop_back();
        default: begin m_halt = 1; stop = 1; end
      endcase
      if (stop) m_run = 0;
      else if (bus.step_mode) m_pause = 1;
    end
  end

  function automatic int exp_state();
    if (m_err)   return 5;
    if (m_halt)  return 4;
    if (!m_run)  return 0;
    if (m_pause) return 3;
    return m_exec ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_uaddr",  32'(bus.uaddr),     32'(m_addr));
      chk("m_rom_en", 32'(bus.rom_en),    32'(m_run && !m_pause && !m_exec));
      chk("m_exec_en",32'(bus.exec_en),   32'(m_run && m_exec));
      chk("m_busy",   32'(bus.busy),      32'(m_run));
      chk("m_halted", 32'(bus.halted),    32'(m_halt));
      chk("m_err",    32'(bus.err),       32'(m_err));
      chk("m_state",  32'(bus.state_dbg), 32'(exp_state()));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  function automatic logic [23:0] mw(input logic [2:0] nac, input logic [7:0] t);
    return {3'b101, t, 10'h2A5, nac};   // junk in datapath bits must be ignored
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = mw(N_HALT, 8'h00);
  endtask

  task automatic go();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic pulse_step();
    @(posedge clk); #1 bus.step = 1'b1;
    @(posedge clk); #1 bus.step = 1'b0;
  endtask

  task automatic expect_exec(input string nm, input logic [7:0] addr);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus.exec_en === 1'b1) seen = 1'b1;
    end
    if (!seen) chk({nm, "_timeout"}, 32'(0), 32'(1));
    else begin
      chk(nm, 32'(bus.uaddr), 32'(addr));
      prev_exec = last_exec;
      last_exec = cyc;
    end
  endtask

  task automatic wait_halt(input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus.halted === 1'b1) seen = 1'b1;
    end
    chk(nm, 32'(seen), 32'(1));
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_uaddr"}, 32'(bus.uaddr),     32'(8'hFE));
    chk({nm, "_rom"},   32'(bus.rom_en),    32'(0));
    chk({nm, "_exec"},  32'(bus.exec_en),   32'(0));
    chk({nm, "_busy"},  32'(bus.busy),      32'(0));
    chk({nm, "_halt"},  32'(bus.halted),    32'(0));
    chk({nm, "_err"},   32'(bus.err),       32'(0));
    chk({nm, "_state"}, 32'(bus.state_dbg), 32'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outs("rst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.step_mode = 1'b0; bus.step = 1'b0;
    bus.opcode = 4'h0; bus.flag_c = 1'b0; bus.flag_z = 1'b0;
    clear_rom();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; cmp_on = 1'b1;
    @(negedge clk);
    chk_reset_outs("por");

    // Sequential with wrap FE, FF, 00; start latency and 2-cycle throughput.
    rom[8'hFE] = mw(N_NEXT, 8'h00);
    rom[8'hFF] = mw(N_NEXT, 8'h00);
    rom[8'h00] = mw(N_HALT, 8'h00);
    go();
    @(negedge clk);
    chk("lat_rom_en", 32'(bus.rom_en), 32'(1));
    chk("lat_uaddr",  32'(bus.uaddr),  32'(8'hFE));
    expect_exec("wrap_fe", 8'hFE);
    expect_exec("wrap_ff", 8'hFF);
    chk("wrap_period1", 32'(last_exec - prev_exec), 32'(2));
    expect_exec("wrap_00", 8'h00);
    chk("wrap_period2", 32'(last_exec - prev_exec), 32'(2));
    wait_halt("wrap_halted");
    chk("halt_holds_uaddr", 32'(bus.uaddr), 32'(8'h00));

    // Carry and zero branches, both outcomes.
    clear_rom();
    rom[8'hFE] = mw(N_JUMP, 8'h10);
    rom[8'h10] = mw(N_BRC, 8'h40);
    bus.flag_c = 1'b0;
    go(); expect_exec("j_fe", 8'hFE); expect_exec("brc_at10", 8'h10);
    expect_exec("brc_nt", 8'h11); wait_halt("brc_nt_h");
    bus.flag_c = 1'b1;
    go(); expect_exec("j_fe2", 8'hFE); expect_exec("brc_at10b", 8'h10);
    expect_exec("brc_t", 8'h40); wait_halt("brc_t_h");
    rom[8'h10] = mw(N_BRZ, 8'h40);
    bus.flag_z = 1'b0;
    go(); expect_exec("j_fe3", 8'hFE); expect_exec("brz_at10", 8'h10);
    expect_exec("brz_nt", 8'h11); wait_halt("brz_nt_h");
    bus.flag_z = 1'b1; bus.flag_c = 1'b0;
    go(); expect_exec("j_fe4", 8'hFE); expect_exec("brz_at10b", 8'h10);
    expect_exec("brz_t", 8'h40); wait_halt("brz_t_h");
    bus.flag_z = 1'b0;

    // Dispatch on opcode A.
    clear_rom();
    rom[8'hFE] = mw(N_DISP, 8'h00);
    bus.opcode = 4'hA;
    go(); expect_exec("disp_fe", 8'hFE); expect_exec("disp_a0", 8'hA0);
    wait_halt("disp_h");

    // Nested call / return.
    clear_rom();
    rom[8'hFE] = mw(N_JUMP, 8'h05);
    rom[8'h05] = mw(N_CALL, 8'h30);
    rom[8'h30] = mw(N_NEXT, 8'h00);
    rom[8'h31] = mw(N_CALL, 8'h50);
    rom[8'h50] = mw(N_RET,  8'h00);
    rom[8'h32] = mw(N_RET,  8'h00);
    rom[8'h06] = mw(N_HALT, 8'h00);
    go();
    expect_exec("cr_fe", 8'hFE); expect_exec("cr_05", 8'h05);
    expect_exec("cr_30", 8'h30); expect_exec("cr_31", 8'h31);
    expect_exec("cr_50", 8'h50); expect_exec("cr_32", 8'h32);
    expect_exec("cr_06", 8'h06); wait_halt("cr_h");

    // Leave one entry on the stack, then restart into RET: the restart must
    // have emptied the stack, so RET underflows.
    clear_rom();
    rom[8'hFE] = mw(N_CALL, 8'h20);
    go(); expect_exec("uf_call", 8'hFE); expect_exec("uf_20", 8'h20);
    wait_halt("uf_h");
    rom[8'hFE] = mw(N_RET, 8'h00);
    go(); expect_exec("uf_ret_exec", 8'hFE);
    @(negedge clk);
    chk("uf_state", 32'(bus.state_dbg), 32'(5));
    chk("uf_err",   32'(bus.err),       32'(1));
    chk("uf_busy",  32'(bus.busy),      32'(0));
    do_reset();

    // Overflow on the 5th nested CALL.
    clear_rom();
    rom[8'hFE] = mw(N_JUMP, 8'h60);
    for (int i = 0; i < 5; i++) rom[8'h60 + i] = mw(N_CALL, 8'(8'h61 + i));
    go(); expect_exec("of_fe", 8'hFE);
    expect_exec("of_c1", 8'h60); expect_exec("of_c2", 8'h61);
    expect_exec("of_c3", 8'h62); expect_exec("of_c4", 8'h63);
    expect_exec("of_c5", 8'h64);
    @(negedge clk);
    chk("of_state", 32'(bus.state_dbg), 32'(5));
    chk("of_err",   32'(bus.err),       32'(1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("of_no_fetch", 32'(bus.rom_en | bus.exec_en), 32'(0));
    end
    chk("of_uaddr_hold", 32'(bus.uaddr), 32'(8'h64));
    do_reset();

    // Single-step, HALT priority over PAUSE, and leaving PAUSE by dropping
    // step_mode.
    clear_rom();
    rom[8'hFE] = mw(N_NEXT, 8'h00);
    rom[8'hFF] = mw(N_NEXT, 8'h00);
    bus.step_mode = 1'b1;
    go(); expect_exec("st_fe", 8'hFE);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("st_pause_busy",  32'(bus.busy),      32'(1));
      chk("st_pause_nofet", 32'(bus.rom_en),    32'(0));
      chk("st_pause_state", 32'(bus.state_dbg), 32'(3));
    end
    pulse_step(); expect_exec("st_ff", 8'hFF);
    @(negedge clk);
    chk("st_pause2", 32'(bus.state_dbg), 32'(3));
    pulse_step(); expect_exec("st_00", 8'h00);
    @(negedge clk);
    chk("st_halt_prio", 32'(bus.state_dbg), 32'(4));
    chk("st_halted",    32'(bus.halted),    32'(1));
    go(); expect_exec("sd_fe", 8'hFE);
    @(negedge clk);
    chk("sd_paused", 32'(bus.state_dbg), 32'(3));
    @(posedge clk); #1 bus.step_mode = 1'b0;
    expect_exec("sd_ff", 8'hFF); expect_exec("sd_00", 8'h00);
    wait_halt("sd_h");

    // start while busy is ignored; then asynchronous reset during EXEC.
    clear_rom();
    rom[8'hFE] = mw(N_NEXT, 8'h00);
    rom[8'hFF] = mw(N_JUMP, 8'hFF);
    go(); expect_exec("bs_fe", 8'hFE); expect_exec("bs_ff", 8'hFF);
    go(); expect_exec("bs_ignored", 8'hFF);
    #1 rst = 1'b1;
    #1 chk_reset_outs("arst");
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("arst_no_exec", 32'(bus.exec_en | bus.rom_en), 32'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/useq_ctrl.md
# useq_ctrl

Microprogram sequencer for the 8-bit microcoded CPU datapath. It generates the control-store address, and fetches and issues 24-bit microwords one at a time. It resolves next-address control (sequential, jump, dispatch, conditional branch, call/return through a small hardware stack) and gates every datapath write with a single execute strobe. It replaces the free-running address counter: register files, ALU and decoders consume `uword` only while `exec_en` is high.

## Interface
Parameters:
- `STACK_DEPTH`, default 4: micro-return stack entries. Legal values are 2..8.
- `RESET_ADDR`, default 8'h00: microaddress the sequencer starts from.

Ports:
- `clk`  in  1: single system clock. All state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: level sampled in IDLE/HALT. Begins or restarts execution.
- `step_mode`  in  1: when 1, execution pauses after every microinstruction.
- `step`  in  1: one-cycle pulse that releases one paused microinstruction.
- `uword`  in  24: control-store data. Valid the cycle after `rom_en`.
- `opcode`  in  4: IR opcode, used for dispatch.
- `flag_c`  in  1: carry flag from the status register.
- `flag_z`  in  1: zero flag from the status register.
- `uaddr`  out  8: registered control-store address.
- `rom_en`  out  1: fetch strobe. The ROM latches `uaddr` on this edge.
- `exec_en`  out  1: one-cycle strobe. Datapath write enables are ANDed with it.
- `busy`  out  1: high in FETCH, EXEC or PAUSE.
- `halted`  out  1: high in HALT.
- `err`  out  1: sticky stack fault.
- `state_dbg`  out  3: encoded state, for the LED debug bus.

## Operation
- Microword sequencing fields:
  - `uword[2:0]` is the next-address control (NAC).
  - `uword[20:13]` is the branch target T.
  - Other bits pass through to the datapath and are ignored here.
- NAC encoding:
  - 000 NEXT: uaddr+1.
  - 001 DISPATCH: {opcode, 4'b0000}.
  - 010 JUMP: T.
  - 011 BRC: T if `flag_c`, else uaddr+1.
  - 100 BRZ: T if `flag_z`, else uaddr+1.
  - 101 CALL: push uaddr+1, then go to T.
  - 110 RET: pop the stack into uaddr.
  - 111 HALT.
- States, with encodings:
  - IDLE=0, FETCH=1, EXEC=2, PAUSE=3, HALT=4, ERR=5.
- Transitions:
  - IDLE: `start` -> FETCH, with `uaddr`=RESET_ADDR.
  - FETCH: `rom_en`=1 for one cycle -> EXEC.
  - EXEC: `exec_en`=1 for one cycle and the next address is loaded.
    - NAC=HALT -> HALT; `uaddr` holds.
    - Stack fault -> ERR.
    - Otherwise, `step_mode` -> PAUSE, else -> FETCH.
  - PAUSE: `step` -> FETCH. Dropping `step_mode` while paused also -> FETCH.
  - HALT: `start` -> FETCH with `uaddr`=RESET_ADDR and the stack emptied.
  - ERR: held until `rst`. No `rom_en` and no `exec_en` in ERR.
- Stack:
  - LIFO of 8-bit entries with pointer `sp` (0 = empty).
  - CALL with `sp`==STACK_DEPTH is overflow. RET with `sp`==0 is underflow.
  - On either fault: `err`=1, no push/pop, and the datapath write for that microword still occurs (`exec_en` asserted).
- Arithmetic: uaddr+1 is modulo 256, so 8'hFF NEXT -> 8'h00. There is no fault on wrap.
- Flags are sampled in EXEC, i.e. the values produced by the previous microinstruction's write.

## Timing
- Reset values:
  - IDLE state, `uaddr`=RESET_ADDR, `sp`=0.
  - `rom_en`=0, `exec_en`=0, `busy`=0, `halted`=0, `err`=0, `state_dbg`=0.
- `rst` mid-instruction aborts immediately and asynchronously. No partial `exec_en` pulse is produced after assertion.
- Throughput is 2 cycles per microinstruction in free-run. In `step_mode` each microinstruction costs 2 cycles plus the pause.
- Latency: `start` high at edge N gives `rom_en` in cycle N+1, the first `exec_en` in N+2, and the next `uaddr` valid in N+3.
- `uaddr` changes only on the EXEC->next edge, or on the start/restart load. It is stable through FETCH and EXEC.
- `step` asserted outside PAUSE is ignored; it is not queued. `start` while `busy` is ignored.
- In EXEC with NAC=HALT and `step_mode`=1, HALT takes priority over PAUSE.

## Test plan
- Sequential/wrap: RESET_ADDR=8'hFE, words at FE and FF with NAC=NEXT -> `uaddr` sequence FE, FF, 00. `exec_en` is high every 2nd cycle.
- Branches:
  - BRC to T=8'h40 with `flag_c`=0 at uaddr 8'h10 -> 8'h11.
  - Same with `flag_c`=1 -> 8'h40.
  - BRZ behaves the same way with `flag_z`.
- Dispatch: `opcode`=4'hA, NAC=DISPATCH -> `uaddr`=8'hA0.
- Call/return nesting:
  - CALL from 8'h05 to 8'h30, then CALL from 8'h31 to 8'h50, RET, RET -> `uaddr` 30, 50, 32, 06.
  - 5 nested CALLs with STACK_DEPTH=4 -> `err`=1 and state ERR after the 5th EXEC.
  - RET on an empty stack -> ERR.
- Step/halt: `step_mode`=1 -> `busy` stays high and no `rom_en` until a `step` pulse. HALT word -> `halted`=1. `start` -> refetch at RESET_ADDR with the stack empty.
- Async reset: assert `rst` during EXEC -> all outputs reach reset values before the next edge. No `exec_en` pulse until `start` is given again.
